// File: rtl/risc16_mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the RiSC-16 datapath,
// sharing one req/ack memory port between instruction fetch and LW/SW, with halt and ack-timeout fault.
`default_nettype none

module risc16_mc_sequencer #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [15:0] instr,
   input  logic       eq,
   input  logic       mem_ack,
   output logic       mem_req,
   output logic       mem_we,
   output logic       mem_addr_sel,
   output logic       ir_we,
   output logic       mdr_we,
   output logic       pc_we,
   output logic [1:0] func_alu,
   output logic       mux_alu1,
   output logic       mux_alu2,
   output logic       mux_rf,
   output logic [1:0] mux_pc,
   output logic [1:0] mux_tgt,
   output logic       we_rf,
   output logic       retire,
   output logic       halted,
   output logic       fault
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
   } state_t;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_ADDI = 3'b001;
   localparam logic [2:0] OP_NAND = 3'b010;
   localparam logic [2:0] OP_LUI  = 3'b011;
   localparam logic [2:0] OP_SW   = 3'b100;
   localparam logic [2:0] OP_LW   = 3'b101;
   localparam logic [2:0] OP_BEQ  = 3'b110;
   localparam logic [2:0] OP_JALR = 3'b111;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         op;
   logic               is_halt;
   logic               wd_expire;
   logic [1:0]         alu_func;
   logic               alu_a1, alu_a2, rf_sel;
   logic               unused_instr_bits;

   assign op                = instr[15:13];
   assign is_halt           = (op == OP_JALR) && (instr[6:0] != 7'd0);
   assign unused_instr_bits = ^instr[12:7];

   // Watchdog only fires on a request cycle that is still unanswered at the limit.
   assign wd_expire = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT)) && !mem_ack;

   always_comb begin
      alu_func = 2'b00;
      alu_a1   = 1'b0;
      alu_a2   = 1'b0;
      rf_sel   = (op == OP_ADD) || (op == OP_NAND);
      case (op)
         OP_ADDI, OP_SW, OP_LW: alu_a2   = 1'b1;
         OP_NAND:               alu_func = 2'b01;
         OP_LUI: begin
            alu_func = 2'b10;
            alu_a1   = 1'b1;
         end
         OP_BEQ:                alu_func = 2'b11;
         OP_JALR:               alu_func = 2'b10;
         default:               alu_func = 2'b00;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      mdr_we       = 1'b0;
      pc_we        = 1'b0;
      func_alu     = 2'b00;
      mux_alu1     = 1'b0;
      mux_alu2     = 1'b0;
      mux_rf       = 1'b0;
      mux_pc       = 2'b00;
      mux_tgt      = 2'b00;
      we_rf        = 1'b0;
      retire       = 1'b0;
      halted       = 1'b0;
      fault        = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               ir_we   = 1'b1;
               state_d = S_DECODE;
            end else if (wd_expire) begin
               state_d = S_FAULT;
            end
         end
         S_DECODE: begin
            mux_rf  = rf_sel;
            state_d = is_halt ? S_HALT : S_EXEC;
         end
         S_EXEC: begin
            func_alu = alu_func;
            mux_alu1 = alu_a1;
            mux_alu2 = alu_a2;
            mux_rf   = rf_sel;
            state_d  = S_FETCH;
            case (op)
               OP_SW, OP_LW: state_d = S_MEM;
               OP_BEQ: begin
                  pc_we  = 1'b1;
                  mux_pc = eq ? 2'b10 : 2'b01;
                  retire = 1'b1;
               end
               OP_JALR: begin
                  we_rf   = 1'b1;
                  mux_tgt = 2'b10;
                  pc_we   = 1'b1;
                  mux_pc  = 2'b00;
                  retire  = 1'b1;
               end
               default: begin
                  we_rf   = 1'b1;
                  mux_tgt = 2'b00;
                  pc_we   = 1'b1;
                  mux_pc  = 2'b01;
                  retire  = 1'b1;
               end
            endcase
         end
         S_MEM: begin
            func_alu     = alu_func;
            mux_alu1     = alu_a1;
            mux_alu2     = alu_a2;
            mux_rf       = rf_sel;
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = (op == OP_SW);
            if (mem_ack) begin
               if (op == OP_SW) begin
                  pc_we   = 1'b1;
                  mux_pc  = 2'b01;
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  mdr_we  = 1'b1;
                  state_d = S_WB;
               end
            end else if (wd_expire) begin
               state_d = S_FAULT;
            end
         end
         S_WB: begin
            we_rf   = 1'b1;
            mux_tgt = 2'b01;
            pc_we   = 1'b1;
            mux_pc  = 2'b01;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_HALT:  halted = 1'b1;
         S_FAULT: fault  = 1'b1;
      endcase
   end

   // Counter is zero whenever no request is pending, so entry to FETCH/MEM starts it clean.
   always_comb begin
      cnt_d = '0;
      if (mem_req && !mem_ack) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_risc16_mc_sequencer.sv
// Randomized bench for risc16_mc_sequencer: a phase-level reference model expands each
// instruction into expected per-cycle outputs, compared against the DUT every cycle.
`default_nettype none

module tb_risc16_mc_sequencer;

   typedef struct packed {
      logic       req, we, asel, irwe, mdrwe, pcwe;
      logic [1:0] func;
      logic       a1, a2, rf;
      logic [1:0] mpc, mtgt;
      logic       wrf, ret, hlt, flt;
   } ov_t;

   typedef struct packed {
      logic [15:0] ins;
      logic        e;
      logic        ack;
      ov_t         exp;
   } cyc_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] instr = 16'h0;
   logic        eq = 1'b0;
   logic        mem_ack = 1'b0;
   logic        mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, pc_we;
   logic [1:0]  func_alu, mux_pc, mux_tgt;
   logic        mux_alu1, mux_alu2, mux_rf, we_rf, retire, halted, fault;
   ov_t         obs;
   cyc_t        q[$];
   int          checks = 0;
   int          errors = 0;

   localparam int TO = 4;

   risc16_mc_sequencer #(.TIMEOUT(TO), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .eq(eq), .mem_ack(mem_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
      .ir_we(ir_we), .mdr_we(mdr_we), .pc_we(pc_we), .func_alu(func_alu),
      .mux_alu1(mux_alu1), .mux_alu2(mux_alu2), .mux_rf(mux_rf),
      .mux_pc(mux_pc), .mux_tgt(mux_tgt), .we_rf(we_rf), .retire(retire),
      .halted(halted), .fault(fault)
   );

   assign obs = {mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, pc_we, func_alu,
                 mux_alu1, mux_alu2, mux_rf, mux_pc, mux_tgt, we_rf, retire, halted, fault};

   always #5 clk = ~clk;

   // ALU-side controls from the opcode table; held through EXEC and MEM.
   function automatic ov_t with_alu(input ov_t v, input logic [2:0] op);
      ov_t r = v;
      r.rf = (op == 3'd0) || (op == 3'd2);
      case (op)
         3'd1, 3'd4, 3'd5: begin r.func = 2'b00; r.a2 = 1'b1; end
         3'd2:             r.func = 2'b01;
         3'd3:             begin r.func = 2'b10; r.a1 = 1'b1; end
         3'd6:             r.func = 2'b11;
         3'd7:             r.func = 2'b10;
         default:          r.func = 2'b00;
      endcase
      return r;
   endfunction

   task automatic push(input logic [15:0] ins, input logic e, input logic ack, input ov_t v);
      cyc_t c;
      c.ins = ins; c.e = e; c.ack = ack; c.exp = v;
      q.push_back(c);
   endtask

   // Expands one instruction into its expected cycles; fw/mw = unanswered request cycles.
   task automatic model_instr(input logic [15:0] ins, input int fw, input int mw, input logic e);
      ov_t        v;
      logic [2:0] op;
      op = ins[15:13];
      for (int i = 0; i < fw; i++) begin
         v = '0; v.req = 1'b1;
         push(ins, e, 1'b0, v);
      end
      v = '0; v.req = 1'b1; v.irwe = 1'b1;
      push(ins, e, 1'b1, v);
      v = '0; v.rf = (op == 3'd0) || (op == 3'd2);
      push(ins, e, 1'($urandom_range(1)), v);
      if (op == 3'd7 && ins[6:0] != 7'd0) return;
      v = with_alu('0, op);
      if (op <= 3'd3) begin
         v.wrf = 1'b1; v.pcwe = 1'b1; v.mpc = 2'b01; v.ret = 1'b1;
      end else if (op == 3'd6) begin
         v.pcwe = 1'b1; v.mpc = e ? 2'b10 : 2'b01; v.ret = 1'b1;
      end else if (op == 3'd7) begin
         v.wrf = 1'b1; v.mtgt = 2'b10; v.pcwe = 1'b1; v.mpc = 2'b00; v.ret = 1'b1;
      end
      push(ins, e, 1'($urandom_range(1)), v);
      if (op == 3'd4 || op == 3'd5) begin
         for (int i = 0; i <= mw; i++) begin
            v = with_alu('0, op);
            v.req = 1'b1; v.asel = 1'b1; v.we = (op == 3'd4);
            if (i == mw) begin
               if (op == 3'd4) begin
                  v.pcwe = 1'b1; v.mpc = 2'b01; v.ret = 1'b1;
               end else begin
                  v.mdrwe = 1'b1;
               end
            end
            push(ins, e, (i == mw), v);
         end
         if (op == 3'd5) begin
            v = '0; v.wrf = 1'b1; v.mtgt = 2'b01; v.pcwe = 1'b1; v.mpc = 2'b01; v.ret = 1'b1;
            push(ins, e, 1'($urandom_range(1)), v);
         end
      end
   endtask

   task automatic run_q(input string name);
      cyc_t c;
      for (int i = 0; i < q.size(); i++) begin
         c = q[i];
         @(negedge clk);
         instr = c.ins; eq = c.e; mem_ack = c.ack;
         #1;
         checks++;
         if (obs !== c.exp) begin
            errors++;
            $display("FAIL %s cyc %0d: got %h want %h", name, i, obs, c.exp);
         end
      end
      q.delete();
   endtask

   task automatic do_reset(input string name);
      @(negedge clk);
      rst_n = 1'b0; mem_ack = 1'b1;
      #1;
      checks++;
      if (obs !== ov_t'(0)) begin
         errors++;
         $display("FAIL %s_assert: got %h want 0", name, obs);
      end
      @(negedge clk);
      rst_n = 1'b1; mem_ack = 1'b0;
      #1;
      checks++;
      if (obs !== ov_t'(0)) begin
         errors++;
         $display("FAIL %s_idle: got %h want 0", name, obs);
      end
   endtask

   task automatic test_reset;
      do_reset("reset");
   endtask

   task automatic test_add;
      do_reset("add_rst");
      model_instr(16'h0481, 0, 0, 1'b0);
      model_instr(16'h0481, 0, 0, 1'b1);
      run_q("add");
   endtask

   task automatic test_lw;
      model_instr(16'hA482, 0, 3, 1'b0);
      run_q("lw");
   endtask

   task automatic test_beq;
      model_instr(16'hC483, 0, 0, 1'b1);
      model_instr(16'hC483, 1, 0, 1'b0);
      run_q("beq");
   endtask

   task automatic test_sw_jalr;
      model_instr(16'h8482, 2, 1, 1'b0);
      model_instr(16'hE080, 0, 0, 1'b0);
      run_q("sw_jalr");
   endtask

   task automatic test_random;
      logic [15:0] ins;
      for (int n = 0; n < 150; n++) begin
         ins = 16'($urandom);
         if (ins[15:13] == 3'd7) ins[6:0] = 7'd0;
         model_instr(ins, $urandom_range(TO), $urandom_range(TO), 1'($urandom_range(1)));
      end
      run_q("random");
   endtask

   task automatic test_halt;
      ov_t v;
      do_reset("halt_rst");
      model_instr(16'hE071, 1, 0, 1'b0);
      v = '0; v.hlt = 1'b1;
      for (int i = 0; i < 20; i++) push(16'hE071, 1'b0, 1'($urandom_range(1)), v);
      run_q("halt");
      do_reset("halt_clear");
   endtask

   task automatic test_fault;
      ov_t v;
      v = '0; v.req = 1'b1;
      for (int i = 0; i <= TO; i++) push(16'h0481, 1'b0, 1'b0, v);
      v = '0; v.flt = 1'b1;
      for (int i = 0; i < 6; i++) push(16'h0481, 1'b0, 1'($urandom_range(1)), v);
      run_q("fault_fetch");
      do_reset("fault_clear");
      model_instr(16'h0481, TO, 0, 1'b0);
      model_instr(16'hA482, 0, TO, 1'b0);
      run_q("ack_at_limit");
      v = '0; v.req = 1'b1; v.asel = 1'b1; v.we = 1'b1;
      v = with_alu(v, 3'd4);
      model_instr(16'h8482, 0, 0, 1'b0);
      q.pop_back();
      for (int i = 0; i <= TO; i++) push(16'h8482, 1'b0, 1'b0, v);
      v = '0; v.flt = 1'b1;
      for (int i = 0; i < 3; i++) push(16'h8482, 1'b0, 1'b0, v);
      run_q("fault_mem");
      do_reset("fault_mem_clear");
   endtask

   task automatic test_reset_mid_mem;
      model_instr(16'hA482, 0, 3, 1'b0);
      repeat (3) void'(q.pop_back());
      run_q("pre_mid_reset");
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== ov_t'(0)) begin
         errors++;
         $display("FAIL mid_mem_reset: got %h want 0", obs);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (obs !== ov_t'(0)) begin
         errors++;
         $display("FAIL mid_mem_idle: got %h want 0", obs);
      end
      model_instr(16'h2481, 0, 0, 1'b0);
      run_q("after_mid_reset");
   endtask

   initial begin
      test_reset();
      test_add();
      test_lw();
      test_beq();
      test_sw_jalr();
      test_random();
      test_halt();
      test_fault();
      test_reset_mid_mem();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
